// File: rtl/centralized_buffer_reader_pkg.sv
// cbr_pkg: shared widths, FSM states and word descriptor codes for the PCB reader
package cbr_pkg;
  localparam int BUFID_W = 9;
  localparam int WORD_LOG2 = 7;
  localparam int ADDR_W = BUFID_W + WORD_LOG2;
  localparam int DATA_W = 134;
  localparam int WORDS_PER_BUF = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, SEND = 2'd2} state_t;
  localparam logic [1:0] DESC_HEAD = 2'b01;
  localparam logic [1:0] DESC_BODY = 2'b11;
  localparam logic [1:0] DESC_TAIL = 2'b10;
endpackage

// File: rtl/centralized_buffer_reader_if.sv
// centralized_buffer_reader_if: scheduler request, PCB read port and downstream stream
interface centralized_buffer_reader_if;
  import cbr_pkg::*;
  logic [BUFID_W-1:0] iv_bufid;
  logic i_bufid_wr;
  logic o_bufid_ack;
  logic o_data_rd;
  logic [ADDR_W-1:0] ov_data_raddr;
  logic [DATA_W-1:0] iv_rdata;
  logic i_rdata_ack;
  logic [DATA_W-1:0] ov_data;
  logic o_data_wr;
  logic i_data_ready;
  logic o_bufid_release;
  logic [BUFID_W-1:0] ov_release_bufid;
  logic o_len_err;
  logic [15:0] ov_debug_rd_pkt_cnt;
  modport slave (
    input iv_bufid, i_bufid_wr, iv_rdata, i_rdata_ack, i_data_ready,
    output o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
    output o_bufid_release, ov_release_bufid, o_len_err, ov_debug_rd_pkt_cnt
  );
  modport master (
    output iv_bufid, i_bufid_wr, iv_rdata, i_rdata_ack, i_data_ready,
    input o_bufid_ack, o_data_rd, ov_data_raddr, ov_data, o_data_wr,
    input o_bufid_release, ov_release_bufid, o_len_err, ov_debug_rd_pkt_cnt
  );
endinterface

// File: rtl/centralized_buffer_reader.sv
// centralized_buffer_reader: streams one PCB buffer word by word to the transmit path, then releases it
// Optional packet counter on ov_debug_rd_pkt_cnt built under CENTRALIZED_BUFFER_READER_DEBUG_EN.
module centralized_buffer_reader
  import cbr_pkg::*;
(
  input logic i_clk,
  input logic i_rst,
  centralized_buffer_reader_if.slave bus
);
  state_t st, nxt;
  logic [BUFID_W-1:0] bufid;
  logic [WORD_LOG2-1:0] off;
  logic acc, ack, snd, tail, last;
  always_comb begin
    acc = st == IDLE && bus.i_bufid_wr;
    ack = st == WAIT_ACK && bus.i_rdata_ack;
    snd = st == SEND && bus.i_data_ready;
    tail = bus.ov_data[DATA_W-1 -: 2] == DESC_TAIL;
    last = &off && bus.iv_rdata[DATA_W-1 -: 2] != DESC_TAIL;
    nxt = acc ? WAIT_ACK : ack ? SEND : snd ? (tail ? IDLE : WAIT_ACK) : st;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) st <= IDLE;
    else st <= nxt;
  // offset wraps within 7 bits so the address never leaves the buffer
  assign bus.ov_data_raddr = {bufid, off};
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      bufid <= '0;
      off <= '0;
      bus.o_bufid_ack <= 1'b0;
      bus.o_data_rd <= 1'b0;
      bus.ov_data <= '0;
      bus.o_data_wr <= 1'b0;
      bus.o_bufid_release <= 1'b0;
      bus.ov_release_bufid <= '0;
      bus.o_len_err <= 1'b0;
    end else begin
      bus.o_bufid_ack <= acc;
      bus.o_bufid_release <= snd && tail;
      bus.o_len_err <= ack && last;
      if (acc) begin
        bufid <= bus.iv_bufid;
        off <= '0;
      end else if (snd && !tail) off <= off + 7'd1;
      if (acc || (snd && !tail)) bus.o_data_rd <= 1'b1;
      else if (ack) bus.o_data_rd <= 1'b0;
      if (ack) begin
        bus.ov_data <= last ? {DESC_TAIL, bus.iv_rdata[DATA_W-3:0]} : bus.iv_rdata;
        bus.o_data_wr <= 1'b1;
      end else if (snd) bus.o_data_wr <= 1'b0;
      if (snd && tail) bus.ov_release_bufid <= bufid;
    end
`ifdef CENTRALIZED_BUFFER_READER_DEBUG_EN
  logic [15:0] pkt_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) pkt_cnt <= '0;
    else if (snd && tail) pkt_cnt <= pkt_cnt + 16'd1;
  assign bus.ov_debug_rd_pkt_cnt = pkt_cnt;
`else
  assign bus.ov_debug_rd_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_centralized_buffer_reader.sv
// tb_centralized_buffer_reader: directed packets with a scoreboard monitor for the PCB reader
module tb_centralized_buffer_reader;
  import cbr_pkg::*;
`ifdef CENTRALIZED_BUFFER_READER_DEBUG_EN
  localparam int DBG = 1;
`else
  localparam int DBG = 0;
`endif
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;
  centralized_buffer_reader_if bus();
  centralized_buffer_reader dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  int total = 0, passed = 0;
  int rel_cnt = 0, ack_cnt = 0, len_cnt = 0;
  int ack_dly = 0, rdy_dly = 0;
  logic spur = 1'b0;
  logic [1:0] desc_tab [WORDS_PER_BUF];
  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  logic [BUFID_W-1:0] q_rel [$];
  function automatic logic [DATA_W-1:0] mkword(logic [1:0] d, logic [ADDR_W-1:0] a);
    return {d, {8{a}}, 4'h5};
  endfunction
  task automatic chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic chki(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic fail(string nm);
    total++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask
  task automatic push_exp(logic [BUFID_W-1:0] b, int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] d = desc_tab[i];
      logic [ADDR_W-1:0] a = {b, 7'(i)};
      if (i == WORDS_PER_BUF - 1 && d != DESC_TAIL) d = DESC_TAIL;
      q_addr.push_back(a);
      q_data.push_back(mkword(d, a));
    end
    q_rel.push_back(b);
  endtask
  task automatic wait_ack();
    int k = 0;
    do begin
      @(posedge i_clk); #1;
      k++;
    end while (!bus.o_bufid_ack && k < 3000);
    if (!bus.o_bufid_ack) fail("ack_timeout");
  endtask
  task automatic request(logic [BUFID_W-1:0] b);
    bus.iv_bufid = b;
    bus.i_bufid_wr = 1'b1;
    wait_ack();
    bus.i_bufid_wr = 1'b0;
  endtask
  task automatic wait_rel(int target);
    int k = 0;
    while (rel_cnt < target && k < 3000) begin
      @(posedge i_clk); #1;
      k++;
    end
    chki("release_count", rel_cnt, target);
  endtask
  // PCB model: answers each read after ack_dly idle cycles
  initial begin
    int c = 0;
    forever begin
      @(posedge i_clk); #1;
      bus.i_rdata_ack = spur;
      if (bus.o_data_rd && !i_rst) begin
        if (c < ack_dly) c++;
        else begin
          bus.i_rdata_ack = 1'b1;
          bus.iv_rdata = mkword(desc_tab[bus.ov_data_raddr[6:0]], bus.ov_data_raddr);
          c = 0;
        end
      end else c = 0;
    end
  end
  initial begin
    int c = 0;
    forever begin
      @(posedge i_clk); #1;
      bus.i_data_ready = 1'b0;
      if (bus.o_data_wr) begin
        if (c < rdy_dly) c++;
        else begin
          bus.i_data_ready = 1'b1;
          c = 0;
        end
      end else c = 0;
    end
  end
  initial begin
    logic prd = 1'b0, pwr = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pdat = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (bus.o_data_rd && !prd) begin
          if (q_addr.size() > 0) chki("raddr", int'(bus.ov_data_raddr), int'(q_addr.pop_front()));
          else fail("unexpected_rd");
        end else if (bus.o_data_rd) chki("raddr_hold", int'(bus.ov_data_raddr), int'(paddr));
        if (bus.o_data_wr && pwr) chk("data_hold", bus.ov_data, pdat);
        if (bus.o_data_wr && bus.i_data_ready) begin
          if (q_data.size() > 0) chk("data", bus.ov_data, q_data.pop_front());
          else fail("unexpected_word");
        end
        if (bus.o_bufid_ack) begin
          ack_cnt++;
          chki("rd_with_ack", int'(bus.o_data_rd), 1);
        end
        if (bus.o_bufid_release) begin
          rel_cnt++;
          if (q_rel.size() > 0) chki("release_bufid", int'(bus.ov_release_bufid), int'(q_rel.pop_front()));
          else fail("unexpected_release");
          chki("quiet_on_release", int'({bus.o_data_wr, bus.o_data_rd}), 0);
        end
        if (bus.o_len_err) begin
          len_cnt++;
          chki("len_err_with_wr", int'(bus.o_data_wr), 1);
        end
      end
      prd = bus.o_data_rd;
      pwr = bus.o_data_wr && !bus.i_data_ready;
      paddr = bus.ov_data_raddr;
      pdat = bus.ov_data;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int ac0, r0;
    bus.iv_bufid = '0;
    bus.i_bufid_wr = 1'b0;
    bus.iv_rdata = '0;
    bus.i_rdata_ack = 1'b0;
    bus.i_data_ready = 1'b0;
    for (int i = 0; i < WORDS_PER_BUF; i++) desc_tab[i] = DESC_BODY;
    repeat (3) @(posedge i_clk);
    #1;
    chki("rst_ctrl", int'({bus.o_bufid_ack, bus.o_data_rd, bus.o_data_wr, bus.o_bufid_release, bus.o_len_err}), 0);
    chki("rst_addr", int'(bus.ov_data_raddr), 0);
    chk("rst_data", bus.ov_data, '0);
    chki("rst_dbg", int'(bus.ov_debug_rd_pkt_cnt), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    desc_tab[0] = DESC_HEAD; desc_tab[1] = DESC_BODY; desc_tab[2] = DESC_TAIL;
    push_exp(9'h005, 3);
    request(9'h005);
    wait_rel(1);
    chki("dbg_cnt_1", int'(bus.ov_debug_rd_pkt_cnt), DBG);
    desc_tab[0] = DESC_TAIL;
    push_exp(9'h0A3, 1);
    request(9'h0A3);
    wait_rel(2);
    chki("single_no_len_err", len_cnt, 0);
    ack_dly = 4; rdy_dly = 5;
    desc_tab[0] = DESC_HEAD; desc_tab[1] = DESC_BODY; desc_tab[2] = DESC_TAIL;
    push_exp(9'h042, 3);
    request(9'h042);
    wait_rel(3);
    chki("slow_q_empty", q_data.size(), 0);
    ack_dly = 0; rdy_dly = 0;
    for (int i = 0; i < WORDS_PER_BUF; i++) desc_tab[i] = DESC_BODY;
    push_exp(9'h1FF, WORDS_PER_BUF);
    request(9'h1FF);
    wait_rel(4);
    chki("len_err_once", len_cnt, 1);
    chki("dbg_cnt_4", int'(bus.ov_debug_rd_pkt_cnt), 4 * DBG);
    spur = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    spur = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chki("spur_idle", int'({bus.o_data_wr, bus.o_data_rd}), 0);
    ack_dly = 2;
    desc_tab[0] = DESC_BODY; desc_tab[1] = DESC_TAIL;
    push_exp(9'h011, 2);
    push_exp(9'h012, 2);
    ac0 = ack_cnt;
    bus.iv_bufid = 9'h011;
    bus.i_bufid_wr = 1'b1;
    wait_ack();
    bus.iv_bufid = 9'h012;
    @(posedge i_clk); #1;
    wait_ack();
    bus.i_bufid_wr = 1'b0;
    wait_rel(6);
    chki("held_req_acks", ack_cnt - ac0, 2);
    ack_dly = 10;
    desc_tab[0] = DESC_TAIL;
    q_addr.push_back(16'h1980);
    request(9'h033);
    repeat (3) @(posedge i_clk);
    #1;
    chki("in_wait_ack", int'(bus.o_data_rd), 1);
    r0 = rel_cnt;
    i_rst = 1'b1;
    #1;
    chki("async_rst_ctrl", int'({bus.o_bufid_ack, bus.o_data_rd, bus.o_data_wr, bus.o_bufid_release, bus.o_len_err}), 0);
    chki("async_rst_addr", int'(bus.ov_data_raddr), 0);
    chk("async_rst_data", bus.ov_data, '0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    ack_dly = 0;
    chki("rst_no_release", rel_cnt, r0);
    chki("rst_addr_consumed", q_addr.size(), 0);
    push_exp(9'h034, 1);
    request(9'h034);
    wait_rel(r0 + 1);
    chki("dbg_cnt_after_rst", int'(bus.ov_debug_rd_pkt_cnt), DBG);
    repeat (5) @(posedge i_clk);
    #1;
    chki("final_q_data", q_data.size(), 0);
    chki("final_q_rel", q_rel.size(), 0);
    chki("final_len_err", len_cnt, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
